// File: rtl/tanh_seq_controller_pkg.sv
// Shared definitions for the tanh-unit sequencer: controller state encoding
// and a parameter-legality helper evaluated at elaboration time.
package tanh_seq_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Legal configurations: at least one latency stage, and every restart pulse
  // must correspond to a real pipeline stage.
  function automatic bit params_legal(input int addr_w, input int pipe_lat,
                                      input int num_restart);
    return (addr_w >= 1) && (pipe_lat >= 1) &&
           (num_restart >= 1) && (num_restart <= pipe_lat);
  endfunction

endpackage

// File: rtl/tanh_seq_controller_valid_addr_delay.sv
// Delay line matching the tanh datapath latency. Carries {valid, write address}
// PIPE_LAT stages so the write strobe lines up with the result, plus a short
// "element 0" marker chain whose taps are the per-stage restart pulses.
module tanh_seq_controller_valid_addr_delay #(
  parameter int ADDR_W      = 12,
  parameter int PIPE_LAT    = 3,
  parameter int NUM_RESTART = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   vld_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic                   first_i,
  output logic                   vld_o,
  output logic [ADDR_W-1:0]      addr_o,
  output logic [NUM_RESTART-1:0] restart_o,
  output logic                   pend_o
);

  logic [PIPE_LAT-1:0]    vld_q;
  logic [ADDR_W-1:0]      addr_q [PIPE_LAT];
  logic [NUM_RESTART-1:0] first_q;

  // Shift valid/address and the element-0 marker one stage per cycle; flush drops everything in flight.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      vld_q   <= '0;
      first_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]   <= vld_i;
      addr_q[0]  <= addr_i;
      first_q[0] <= first_i;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
      for (int k = 1; k < NUM_RESTART; k++) first_q[k] <= first_q[k-1];
    end
  end

  // Elements still in flight ahead of the output stage keep the controller draining.
  always_comb begin
    pend_o = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) pend_o = pend_o | vld_q[i];
  end

  assign vld_o     = vld_q[PIPE_LAT-1];
  assign addr_o    = addr_q[PIPE_LAT-1];
  assign restart_o = first_q;

endmodule

// File: rtl/tanh_seq_controller.sv
// Sequencer for the tanh unit: on RUN walks 0..cfg_len_m1 issuing read and
// weight addresses, then drains the datapath while the delay line emits the
// matching write strobes, and pulses DONE once the last result is written.
module tanh_seq_controller
  import tanh_seq_controller_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int PIPE_LAT    = 3,
  parameter int NUM_RESTART = 3,
  parameter int WG_STRIDE   = 1,
  parameter int WR_OFFSET   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   RUN,
  input  logic                   ABORT,
  input  logic [ADDR_W-1:0]      cfg_len_m1,
  output logic [ADDR_W-1:0]      read_address,
  output logic [ADDR_W-1:0]      Wg_address,
  output logic                   write_enable,
  output logic [ADDR_W-1:0]      write_address,
  output logic [NUM_RESTART-1:0] restart_signal,
  output logic                   BUSY,
  output logic                   DONE
);

  generate
    if (!params_legal(ADDR_W, PIPE_LAT, NUM_RESTART)) begin : g_bad_params
      $error("tanh_seq_controller: illegal ADDR_W/PIPE_LAT/NUM_RESTART combination");
    end
  endgenerate

  state_e            state_q, state_d;
  logic              start;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] wg_q;
  logic              busy_q;
  logic              done_q;
  logic              dl_vld;
  logic [ADDR_W-1:0] dl_addr;
  logic              pend;

  // Next-state decode; ABORT overrides every transition and suppresses a start.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RUN && !ABORT) begin
          state_d = ST_ISSUE;
          start   = 1'b1;
        end
      end
      ST_ISSUE:  if (idx_q == len_q) state_d = ST_DRAIN;
      ST_DRAIN:  if (!pend) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (ABORT) begin
      state_d = ST_IDLE;
      start   = 1'b0;
    end
  end

  // State, index counters and status flags; BUSY/DONE registered from the next state so they align with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      wg_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
      done_q  <= (state_d == ST_FINISH);
      if (start) begin
        len_q <= cfg_len_m1;
        idx_q <= '0;
        wg_q  <= '0;
      end else if ((state_q == ST_ISSUE) && (state_d == ST_ISSUE)) begin
        idx_q <= idx_q + ADDR_W'(1);
        wg_q  <= wg_q + ADDR_W'(WG_STRIDE);
      end
    end
  end

  // Each issued element enters the delay line with its final write address; idle slots carry zero.
  always_comb begin
    dl_vld  = (state_q == ST_ISSUE);
    dl_addr = dl_vld ? (idx_q + ADDR_W'(WR_OFFSET)) : '0;
  end

  tanh_seq_controller_valid_addr_delay #(
    .ADDR_W      (ADDR_W),
    .PIPE_LAT    (PIPE_LAT),
    .NUM_RESTART (NUM_RESTART)
  ) u_delay (
    .clock     (clock),
    .reset     (reset),
    .flush_i   (ABORT),
    .vld_i     (dl_vld),
    .addr_i    (dl_addr),
    .first_i   (start),
    .vld_o     (write_enable),
    .addr_o    (write_address),
    .restart_o (restart_signal),
    .pend_o    (pend)
  );

  assign read_address = idx_q;
  assign Wg_address   = wg_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule
